// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared state encodings and default widths for the filter memory control units
package filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_NUM_COEF = 9;

endpackage

// File: rtl/register.sv
// rtl/register.sv - generic N-bit register with load enable and synchronous active-high reset
module register #(
  parameter int           N       = 1,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/filter_load_cu.sv
// rtl/filter_load_cu.sv - turns a valid/ready coefficient stream into one burst of
// consecutive memory writes per start pulse, with a one-cycle done pulse on the last write
module filter_load_cu
  import filter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_COEF  = DEF_NUM_COEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W = $clog2(NUM_COEF + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_COEF - 1);

  logic [1:0]       state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             transfer;
  logic             last;

  register #(.N(2), .RST_VAL(ST_IDLE)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (next_state),
    .q   (state)
  );

  // abort wins over a pending beat so the aborted cycle never produces a write
  assign din_ready = (state == ST_LOAD) && !abort;
  assign transfer  = din_valid && din_ready;
  assign last      = (count == LAST);

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (abort)                 next_state = ST_IDLE;
        else if (transfer && last) next_state = ST_DONE;
        else                       next_state = ST_LOAD;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      addr  <= BASE;
      dout  <= '0;
      en    <= 1'b0;
      wr    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      en   <= transfer;
      wr   <= transfer;
      busy <= (next_state != ST_IDLE);
      done <= (next_state == ST_DONE);
      if (state == ST_IDLE && start) begin
        count <= '0;
        addr  <= BASE;
      end
      if (state == ST_LOAD && abort) begin
        count <= '0;
      end
      if (transfer) begin
        dout  <= din;
        addr  <= BASE + ADDR_W'(count);
        count <= last ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_filter_load_cu.sv
// tb/tb_filter_load_cu.sv - directed and random bursts on a default instance and a
// wrapping-address instance, checked cycle by cycle against a burst-level reference model
module tb_filter_load_cu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start1, abort1, valid1, ready1, en1, wr1, busy1, done1;
  logic [7:0] din1, addr1, dout1;
  logic       start2, abort2, valid2, ready2, en2, wr2, busy2, done2;
  logic [7:0] din2, addr2, dout2;

  filter_load_cu dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .din(din1),
    .din_valid(valid1), .din_ready(ready1), .en(en1), .wr(wr1),
    .addr(addr1), .dout(dout1), .busy(busy1), .done(done1)
  );

  filter_load_cu #(.NUM_COEF(3), .BASE_ADDR(254)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .din(din2),
    .din_valid(valid2), .din_ready(ready2), .en(en2), .wr(wr2),
    .addr(addr2), .dout(dout2), .busy(busy2), .done(done2)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: 0 = idle, 1 = collecting coefficients, 2 = completion cycle
  int         m_phase [2];
  int         m_k     [2];
  int         m_n     [2] = '{9, 3};
  int         m_base  [2] = '{0, 254};
  logic       m_en    [2];
  logic       m_done  [2];
  logic       m_busy  [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_dout  [2];

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_phase[j] = 0; m_k[j] = 0; m_en[j] = 0; m_done[j] = 0; m_busy[j] = 0;
      m_addr[j] = 8'(m_base[j]); m_dout[j] = 8'h00;
    end
  endtask

  task automatic model_edge(input int j, input bit s, input bit a, input bit v, input logic [7:0] d);
    m_en[j]   = 0;
    m_done[j] = 0;
    case (m_phase[j])
      0: if (s) begin m_phase[j] = 1; m_k[j] = 0; m_addr[j] = 8'(m_base[j]); end
      1: begin
        if (a) m_phase[j] = 0;
        else if (v) begin
          m_en[j]   = 1;
          m_addr[j] = 8'((m_base[j] + m_k[j]) % 256);
          m_dout[j] = d;
          m_k[j]++;
          if (m_k[j] == m_n[j]) begin m_phase[j] = 2; m_done[j] = 1; end
        end
      end
      default: m_phase[j] = 0;
    endcase
    m_busy[j] = (m_phase[j] != 0);
  endtask

  task automatic step(input int sel, input bit s, input bit a, input bit v, input logic [7:0] d);
    start1 = 0; abort1 = 0; valid1 = 0; din1 = 8'h00;
    start2 = 0; abort2 = 0; valid2 = 0; din2 = 8'h00;
    if (sel == 0) begin start1 = s; abort1 = a; valid1 = v; din1 = d; end
    else          begin start2 = s; abort2 = a; valid2 = v; din2 = d; end
    #1;
    check_val("din_ready", 32'(sel == 0 ? ready1 : ready2), 32'((m_phase[sel] == 1) && !a));
    if (rst) model_reset();
    else begin
      for (int j = 0; j < 2; j++) begin
        if (j == sel) model_edge(j, s, a, v, d);
        else          model_edge(j, 0, 0, 0, 8'h00);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) begin
      check_val("en", 32'(en1), 32'(m_en[0]));
      check_val("wr", 32'(wr1), 32'(m_en[0]));
      check_val("done", 32'(done1), 32'(m_done[0]));
      check_val("busy", 32'(busy1), 32'(m_busy[0]));
      check_val("addr", 32'(addr1), 32'(m_addr[0]));
      check_val("dout", 32'(dout1), 32'(m_dout[0]));
    end else begin
      check_val("en2", 32'(en2), 32'(m_en[1]));
      check_val("wr2", 32'(wr2), 32'(m_en[1]));
      check_val("done2", 32'(done2), 32'(m_done[1]));
      check_val("busy2", 32'(busy2), 32'(m_busy[1]));
      check_val("addr2", 32'(addr2), 32'(m_addr[1]));
      check_val("dout2", 32'(dout2), 32'(m_dout[1]));
    end
  endtask

  initial begin
    rst = 1;
    start1 = 0; abort1 = 0; valid1 = 0; din1 = 0;
    start2 = 0; abort2 = 0; valid2 = 0; din2 = 0;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    rst = 0;

    // contiguous burst 0x11..0x19
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 8'(8'h11 + i));
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // burst with a gap every other cycle
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 18; i++) step(0, 0, 0, (i % 2) == 0, 8'($urandom));
    step(0, 0, 0, 0, 8'h00);

    // abort after four transfers, then a fresh burst
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'($urandom));
    step(0, 0, 1, 1, 8'hAA);
    step(0, 0, 0, 1, 8'hBB);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'($urandom));

    // wrapping base address instance
    step(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'($urandom));
    step(1, 0, 0, 0, 8'h00);

    // reset during the fifth transfer
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'($urandom));
    rst = 1;
    step(0, 0, 0, 1, 8'h55);
    rst = 0;
    step(0, 0, 0, 1, 8'h66);

    // start during DONE is ignored, start right after DONE is accepted
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 8'($urandom));
    step(0, 1, 0, 1, 8'h77);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'($urandom));

    // random traffic over both instances
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(79, 0) == 0);
      step(int'($urandom_range(1, 0)), $urandom_range(3, 0) == 0,
           $urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0, 8'($urandom));
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filter_load_cu.md
Name: filter_load_cu

Overview:
Write-side control unit for the filter coefficient memory. It accepts a stream of filter weights over a valid/ready handshake and turns it into memory write strobes (en, wr, addr, dout) at consecutive addresses. It runs one load burst per start pulse and flags completion. The filter generation control unit then reads the same memory.

Parameters:
DATA_W, 8, coefficient width in bits
ADDR_W, 8, memory address width in bits
NUM_COEF, 9, coefficients per burst (3x3 kernel); legal range 1..2^ADDR_W
BASE_ADDR, 0, first write address of a burst

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a burst; sampled only in IDLE
abort  in  1  cancel an in-progress burst; sampled only in LOAD
din  in  DATA_W  coefficient data
din_valid  in  1  din holds a valid coefficient
din_ready  out  1  combinational: (state==LOAD) & ~abort
en  out  1  registered memory enable strobe
wr  out  1  registered write select; always equals en
addr  out  ADDR_W  registered write address
dout  out  DATA_W  registered write data
busy  out  1  registered: state != IDLE
done  out  1  registered one-cycle completion pulse

Behaviour:
- Reset values on the clock edge with rst=1:
  - state=IDLE, count=0, addr=BASE_ADDR.
  - en=0, wr=0, dout=0, busy=0, done=0.
  - rst has priority over every other input and works in any state.
- A transfer occurs on a cycle where din_valid & din_ready = 1.
- States are encoded in 2 bits: IDLE=0, LOAD=1, DONE=2. Code 3 is illegal and goes to IDLE.
- IDLE:
  - Outputs: din_ready=0, en=wr=0, done=0.
  - start=1 -> LOAD, with count<=0 and addr held at BASE_ADDR.
- LOAD:
  - On a transfer at edge t: dout<=din, addr<=BASE_ADDR+count (mod 2^ADDR_W), en=wr=1 for the cycle after t, count<=count+1. Write latency is therefore 1 cycle.
  - No transfer: en=wr=0 next cycle; addr and dout hold; count holds.
  - Gaps in din_valid of any length are allowed.
  - A transfer with count==NUM_COEF-1 -> DONE.
  - abort=1 -> IDLE. No write is issued for that cycle, because din_ready is forced to 0. done is not asserted, and count is discarded.
  - start is ignored.
- DONE:
  - Lasts exactly one cycle, with done=1 and the final write strobe (en=wr=1) in that same cycle.
  - din_ready=0, then -> IDLE.
  - start and abort are ignored.
- busy is 1 from the cycle after start is accepted through the DONE cycle inclusive.
- Address arithmetic is ADDR_W bits wide and wraps modulo 2^ADDR_W. Example: BASE_ADDR=0xFE with NUM_COEF=3 writes 0xFE, 0xFF, 0x00.
- count is clog2(NUM_COEF+1) bits wide and never exceeds NUM_COEF-1 while in LOAD.
- Back-to-back bursts: a start in the IDLE cycle immediately after DONE is accepted, giving a minimum 1-cycle gap.
- Reset mid-burst: all outputs return to reset values on the next edge, the partial burst is abandoned, and no done pulse is produced.

Decomposition:
- Shared package filter_pkg holds:
  - state encodings: ST_IDLE, ST_LOAD, ST_DONE
  - defaults: DATA_W=8, ADDR_W=8, NUM_COEF=9
- The state register instantiates the codebase's generic register module (N=2, en tied high). next_state logic stays combinational in this block.
- addr, dout, en/wr, done and count are registers local to this block. No other sub-module.

Test Plan:
- Reset then start; feed din=0x11..0x19 with din_valid held high -> 9 strobes at addr 0x00..0x08, each dout equal to its input, and done=1 only in the cycle of the addr 0x08 strobe, then busy=0.
- Same burst with din_valid low every other cycle -> en=wr=0 in the gap cycles, addr and dout held, all 9 writes correct, done after the 9th write.
- abort asserted after 4 transfers while din_valid=1 -> no 5th write, din_ready=0 that cycle, return to IDLE with no done; a new start then writes from addr 0x00.
- BASE_ADDR=0xFE, NUM_COEF=3 -> writes at 0xFE, 0xFF, 0x00 and done=1 with the 0x00 write.
- rst=1 during the 5th transfer -> en=wr=done=busy=0 and addr=BASE_ADDR next cycle; a start while din_valid=1 in the same cycle as the DONE pulse is ignored.
- start asserted in the IDLE cycle directly after DONE -> second burst accepted, and busy is low for exactly 1 cycle between bursts.
